// File: rtl/instr_seq_pkg.sv
// Shared types and ctrl-word field positions for the instruction sequencer.
package instr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CTRL_W = 7;

  // ctrl word layout: [6:4] opcode, [3:2] waddr/baddr, [1:0] aaddr/shift
  localparam int OPC_MSB    = 6;
  localparam int OPC_LSB    = 4;
  localparam int ADDR_B_MSB = 3;
  localparam int ADDR_B_LSB = 2;
  localparam int ADDR_A_MSB = 1;
  localparam int ADDR_A_LSB = 0;

  function automatic logic [OPC_MSB-OPC_LSB:0] ctrl_opcode(input logic [CTRL_W-1:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/seq_ram.sv
// Microprogram storage: synchronous write, asynchronous read. Contents are not reset.
module seq_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: stores a short microprogram of ctrl words and replays it
// to the control stage with repeat, stall and abort.
// Optional single-step control is compiled in with `define INSTR_SEQ_STEP_EN.
//
// state | meaning
// IDLE  | waiting for a program word or a start pulse
// LOAD  | accepting program words until load_last or the memory is full
// RUN   | issuing one ctrl word per unstalled cycle
// DONE  | final word issued; done pulse is registered out, then IDLE
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int                DEPTH    = 16,
  parameter int                AW       = $clog2(DEPTH),
  parameter logic [CTRL_W-1:0] NOP_CTRL = 7'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [CTRL_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic [7:0]        repeat_cnt,
  input  logic              stall,
  input  logic              abort,
`ifdef INSTR_SEQ_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic [CTRL_W-1:0] ctrl,
  output logic              ctrl_valid,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     pc
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);

  state_t            state, state_nxt;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     waddr;
  logic [AW:0]       len;
  logic [7:0]        iter;
  logic [CTRL_W-1:0] rdata;
  logic              accept;
  logic              step_ok;
  logic              issue;
  logic              at_wrap;
  logic              load_end;

`ifdef INSTR_SEQ_STEP_EN
  assign step_ok = !step_mode || step;
`else
  assign step_ok = 1'b1;
`endif

  assign accept   = load_valid && load_ready;
  assign issue    = (state == RUN) && !stall && step_ok;
  assign at_wrap  = ({1'b0, pc} == (len - LEN_ONE));
  assign load_end = load_last || (wptr == LAST_ADDR);
  // The first word of a new program always lands at address 0.
  assign waddr    = (state == IDLE) ? '0 : wptr;

  seq_ram #(.DEPTH(DEPTH), .AW(AW), .W(CTRL_W)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (waddr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept)                     state_nxt = load_last ? IDLE : LOAD;
        else if (start && (len != '0))  state_nxt = RUN;
      end
      LOAD: begin
        if (abort)                      state_nxt = IDLE;
        else if (accept && load_end)    state_nxt = IDLE;
      end
      RUN: begin
        if (abort)                                  state_nxt = IDLE;
        else if (issue && at_wrap && iter == 8'd1)  state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs; load_ready is held low while reset is asserted
  always_comb begin
    load_ready = !reset && ((state == IDLE) || (state == LOAD));
    busy       = (state == LOAD) || (state == RUN);
  end

  // write pointer, program length, PC, repeat counter and registered ctrl/done
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      len        <= '0;
      pc         <= '0;
      iter       <= '0;
      ctrl       <= NOP_CTRL;
      ctrl_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            // a single-word program closes immediately
            wptr <= load_last ? '0 : ADDR_ONE;
            len  <= load_last ? LEN_ONE : '0;
          end else if (start && (len != '0)) begin
            pc   <= '0;
            iter <= repeat_cnt;
          end
        end
        LOAD: begin
          if (abort) begin
            wptr <= '0;
            len  <= '0;
          end else if (accept) begin
            if (load_end) begin
              len  <= {1'b0, wptr} + LEN_ONE;
              wptr <= '0;
            end else begin
              wptr <= wptr + ADDR_ONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            ctrl       <= NOP_CTRL;
            ctrl_valid <= 1'b0;
          end else if (issue) begin
            ctrl       <= rdata;
            ctrl_valid <= 1'b1;
            if (at_wrap) begin
              pc <= '0;
              if (iter > 8'd1) iter <= iter - 8'd1;
            end else begin
              pc <= pc + ADDR_ONE;
            end
          end
        end
        DONE: begin
          ctrl       <= NOP_CTRL;
          ctrl_valid <= 1'b0;
          done       <= !abort;
        end
        default: begin
          ctrl       <= NOP_CTRL;
          ctrl_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the datapath control stage. Stores a short microprogram of 7-bit ctrl words and replays it to the control stage's ctrl input, one word per unstalled cycle.
- ctrl word field layout: [6:4] opcode, [3:2] waddr/baddr, [1:0] aaddr/shift control.
- Supports a programmable repeat count, stall and abort.
- Replaces hand-driven ctrl vectors in lab benches.

Parameters:
- DEPTH, 16, number of microprogram words; power of two, 2..256.
- AW, $clog2(DEPTH), address/PC width.
- NOP_CTRL, 7'h00, ctrl word driven whenever ctrl_valid=0.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- load_valid  in  1  load_data holds a program word.
- load_ready  out  1  sequencer accepts a program word this cycle.
- load_data  in  7  program word.
- load_last  in  1  final word of the program; qualified by load_valid.
- start  in  1  begin execution; single-cycle pulse.
- repeat_cnt  in  8  number of passes, sampled at start; 0 = loop until abort.
- stall  in  1  hold the current ctrl word and PC.
- abort  in  1  stop execution.
- ctrl  out  7  ctrl word to the control stage.
- ctrl_valid  out  1  ctrl is a program word.
- busy  out  1  state is LOAD or RUN.
- done  out  1  one-cycle pulse at normal completion.
- pc  out  AW  address of the next word to issue.

Behaviour:
- Reset values: state IDLE; pc=0, wptr=0, len=0, iter=0; ctrl=NOP_CTRL; ctrl_valid=0; done=0; load_ready=0. Memory contents are not reset.
- States: IDLE, LOAD, RUN, DONE.
- load_ready=1 in IDLE and LOAD only. A word transfers on load_valid&&load_ready: mem[wptr]<=load_data, wptr++.
- IDLE: an accepted word moves to LOAD, and wptr restarts at 0 for that first word. If load_valid and start are both high, load wins and start is dropped.
- LOAD: ends when the accepted word has load_last=1 or wptr==DEPTH-1. At that point len<=wptr+1 and wptr<=0. The state returns to IDLE on the next cycle. start is ignored while in LOAD.
- IDLE + start with len!=0: pc<=0, iter<=repeat_cnt, enter RUN.
- IDLE + start with len==0: start is ignored.
- RUN, one issue per cycle with stall=0:
  - ctrl<=mem[pc], ctrl_valid<=1.
  - Latency is 1 cycle from the PC value to ctrl.
  - Normally pc<=pc+1.
- RUN, wrap when pc==len-1:
  - If iter==0 (infinite) or iter>1: pc<=0, and iter decrements only if it is nonzero.
  - Otherwise (iter==1): enter DONE after this issue.
- RUN with stall=1: pc, ctrl and ctrl_valid hold. A stall in the same cycle as the last issue delays the DONE transition.
- DONE: ctrl=NOP_CTRL, ctrl_valid=0, done=1 for exactly 1 cycle, then IDLE.
- abort in RUN or DONE: the next cycle is IDLE, with ctrl=NOP_CTRL, ctrl_valid=0 and no done pulse. abort overrides stall.
- abort in LOAD: the partial program is discarded, len<=0, IDLE.
- abort in IDLE: no effect.
- pc wraps modulo DEPTH; for len==DEPTH the wrap coincides with the natural overflow.
- reset mid-RUN: outputs return to reset values on the next edge. The stored len is also cleared, so the program must be reloaded.

Optional Feature:
- Macro: INSTR_SEQ_STEP_EN.
- When defined, adds input ports step_mode (1) and step (1).
- With step_mode=1 in RUN, an issue occurs only in a cycle where step=1 and stall=0. Otherwise ctrl holds and ctrl_valid stays 1 once the first word has issued.
- When undefined, the ports are absent and behaviour is as above.

Decomposition:
- Package instr_seq_pkg:
  - state enum {IDLE, LOAD, RUN, DONE};
  - CTRL_W=7;
  - localparams for ctrl field positions (OPC_MSB=6, OPC_LSB=4, ADDR_B=3:2, ADDR_A=1:0).
- One sub-module, seq_ram: DEPTH x 7 storage with a synchronous write port and an asynchronous read port. Its output is registered in the top level into ctrl.
- FSM, PC and repeat counter live in the top level.

Test Plan:
- Load words 7'h11, 7'h22, 7'h33 with load_last on the third word, then start with repeat_cnt=1 -> ctrl_valid high for exactly 3 consecutive cycles with ctrl 11, 22, 33; done pulse one cycle later; load_ready low during RUN.
- Same program, repeat_cnt=2 -> 6 consecutive issues (11,22,33,11,22,33), then done; pc sequence 0,1,2,0,1,2.
- repeat_cnt=2 with stall held 2 cycles on the second issue -> ctrl=22 for 3 cycles; total RUN length 8 cycles; word order unchanged.
- repeat_cnt=0, abort after 10 issues -> one cycle later ctrl=NOP_CTRL and ctrl_valid=0; done never asserts; busy=0.
- Load DEPTH words without load_last -> len=DEPTH, LOAD ends automatically; start with repeat_cnt=1 -> DEPTH issues, then done.
- reset asserted mid-RUN, then start without reloading -> no issue (len==0), state stays IDLE; start and load_valid in the same cycle -> the word is accepted and no RUN begins.
